// File: rtl/frame_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frame_draw_sequencer
// Brief    : Frame-paced game loop. Requests one logic update per frame, then
//            draws NUM_LAYERS clients in priority order and muxes the active
//            client's pixel stream onto the VGA write port. Tracks over-runs.
//            Build option FRAME_DRAW_LAYER_MASK_EN adds a per-frame layer_mask.
// Revision : 1.0 - initial release
// ============================================================================

module frame_draw_sequencer #(
    parameter int NUM_LAYERS  = 3,
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int COLOUR_W    = 6,
    parameter int FRAME_COUNT = 1000000,
    parameter int CNT_W       = 21,
    parameter int OVR_W       = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           update_done,
    input  logic [NUM_LAYERS-1:0]          layer_done,
    input  logic [NUM_LAYERS-1:0]          layer_write,
    input  logic [NUM_LAYERS*X_W-1:0]      layer_x,
    input  logic [NUM_LAYERS*Y_W-1:0]      layer_y,
    input  logic [NUM_LAYERS*COLOUR_W-1:0] layer_colour,
`ifdef FRAME_DRAW_LAYER_MASK_EN
    input  logic [NUM_LAYERS-1:0]          layer_mask,
`endif
    output logic                           update_req,
    output logic [NUM_LAYERS-1:0]          layer_enable,
    output logic [X_W-1:0]                 x_position,
    output logic [Y_W-1:0]                 y_position,
    output logic [COLOUR_W-1:0]            colour,
    output logic                           VGA_enable,
    output logic                           busy,
    output logic [OVR_W-1:0]               overrun_count
);

    localparam int               IDX_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [CNT_W-1:0] C_TICK_AT = CNT_W'(FRAME_COUNT - 1);
    localparam logic [OVR_W-1:0] C_OVR_MAX = {OVR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_DRAW   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_next_idx;
    logic [NUM_LAYERS-1:0]  w_next_enable;
    logic [CNT_W-1:0]       r_frame_cnt;
    logic                   r_pending;
    logic [OVR_W-1:0]       r_overrun;
    logic                   w_tick;

    logic                   w_cur_done;
    logic                   w_cur_write;
    logic [X_W-1:0]         w_cur_x;
    logic [Y_W-1:0]         w_cur_y;
    logic [COLOUR_W-1:0]    w_cur_colour;
    logic                   w_pixel_valid;

    logic                   r_update_req;
    logic [NUM_LAYERS-1:0]  r_layer_enable;
    logic [X_W-1:0]         r_x;
    logic [Y_W-1:0]         r_y;
    logic [COLOUR_W-1:0]    r_colour;
    logic                   r_vga_en;
    logic                   r_busy;

`ifdef FRAME_DRAW_LAYER_MASK_EN
    logic [NUM_LAYERS-1:0]  r_mask;
`endif

    assign w_tick = (r_frame_cnt == C_TICK_AT);

    // Only the currently indexed client is observed; all others are ignored.
    assign w_cur_done    = layer_done[r_idx];
    assign w_cur_write   = layer_write[r_idx];
    assign w_cur_x       = layer_x[int'(r_idx)*X_W +: X_W];
    assign w_cur_y       = layer_y[int'(r_idx)*Y_W +: Y_W];
    assign w_cur_colour  = layer_colour[int'(r_idx)*COLOUR_W +: COLOUR_W];
    assign w_pixel_valid = (r_state == S_DRAW) && w_cur_write && !w_cur_done;

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_tick || r_pending) begin
                    w_next_state = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (update_done) begin
`ifdef FRAME_DRAW_LAYER_MASK_EN
                    // Lowest unmasked layer wins; an empty mask skips drawing.
                    w_next_state = S_IDLE;
                    w_next_idx   = '0;
                    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
                        if (layer_mask[i]) begin
                            w_next_state = S_DRAW;
                            w_next_idx   = IDX_W'(i);
                        end
                    end
`else
                    w_next_state = S_DRAW;
                    w_next_idx   = '0;
`endif
                end
            end
            S_DRAW: begin
                if (w_cur_done) begin
`ifdef FRAME_DRAW_LAYER_MASK_EN
                    w_next_state = S_IDLE;
                    w_next_idx   = '0;
                    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
                        if (r_mask[i] && (i > int'(r_idx))) begin
                            w_next_state = S_DRAW;
                            w_next_idx   = IDX_W'(i);
                        end
                    end
`else
                    if (r_idx == IDX_W'(NUM_LAYERS - 1)) begin
                        w_next_state = S_IDLE;
                        w_next_idx   = '0;
                    end else begin
                        w_next_idx   = r_idx + IDX_W'(1);
                    end
`endif
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_idx   = '0;
            end
        endcase
    end

    assign w_next_enable = (w_next_state == S_DRAW) ? (NUM_LAYERS'(1) << w_next_idx) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_frame_cnt    <= '0;
            r_pending      <= 1'b0;
            r_overrun      <= '0;
            r_update_req   <= 1'b0;
            r_layer_enable <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_colour       <= '0;
            r_vga_en       <= 1'b0;
            r_busy         <= 1'b0;
`ifdef FRAME_DRAW_LAYER_MASK_EN
            r_mask         <= '0;
`endif
        end else begin
            r_frame_cnt <= w_tick ? '0 : r_frame_cnt + CNT_W'(1);
            r_state     <= w_next_state;
            r_idx       <= w_next_idx;

            // Pending is one deep; further ticks while busy only count.
            if (w_tick && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
                if (r_overrun != C_OVR_MAX) begin
                    r_overrun <= r_overrun + OVR_W'(1);
                end
            end else if ((r_state == S_IDLE) && (w_next_state == S_UPDATE)) begin
                r_pending <= 1'b0;
            end

`ifdef FRAME_DRAW_LAYER_MASK_EN
            if ((r_state == S_UPDATE) && update_done) begin
                r_mask <= layer_mask;
            end
`endif

            r_update_req   <= (w_next_state == S_UPDATE);
            r_busy         <= (w_next_state != S_IDLE);
            r_layer_enable <= w_next_enable;
            r_vga_en       <= w_pixel_valid;
            r_x            <= w_pixel_valid ? w_cur_x      : '0;
            r_y            <= w_pixel_valid ? w_cur_y      : '0;
            r_colour       <= w_pixel_valid ? w_cur_colour : '0;
        end
    end

    assign update_req    = r_update_req;
    assign layer_enable  = r_layer_enable;
    assign x_position    = r_x;
    assign y_position    = r_y;
    assign colour        = r_colour;
    assign VGA_enable    = r_vga_en;
    assign busy          = r_busy;
    assign overrun_count = r_overrun;

endmodule

`default_nettype wire
